// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the MIPS HI/LO registers.
// Optional `MDU_DIV0_FLAG_EN adds a div0 pulse for divide-by-zero completions.
module mdu_sequencer #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic        div0
`endif
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  localparam logic [4:0] LastStep = 5'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic        sgn_q, sgn_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic [63:0] mul_a, mul_b, product;
  logic [32:0] shifted, diff;
  logic        sdiv;

  always_comb begin
    mul_a   = {{32{sgn_q & opa_q[31]}}, opa_q};
    mul_b   = {{32{sgn_q & opb_q[31]}}, opb_q};
    product = mul_a * mul_b;
    // Restoring step: shift next dividend bit into the partial remainder, try subtract.
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    sdiv    = (op == 3'd2);

    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          case (op)
            3'd0, 3'd1: begin
              opa_d   = a;
              opb_d   = b;
              sgn_d   = (op == 3'd0);
              state_d = StMul;
            end
            3'd2, 3'd3: begin
              opa_d   = a;
              dz_d    = (b == 32'd0);
              quo_d   = (sdiv && a[31]) ? -a : a;
              dvs_d   = (sdiv && b[31]) ? -b : b;
              rem_d   = 32'd0;
              qneg_d  = sdiv & (a[31] ^ b[31]);
              rneg_d  = sdiv & a[31];
              cnt_d   = 5'd0;
              state_d = StDiv;
            end
            3'd4:    hi_d = a;
            3'd5:    lo_d = a;
            default: ;
          endcase
        end
      end
      StMul: begin
        {hi_d, lo_d} = product;
        done_d       = 1'b1;
        state_d      = StIdle;
      end
      StDiv: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastStep) state_d = StFix;
      end
      StFix: begin
        if (dz_q) begin
          hi_d = opa_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rneg_q ? -rem_q : rem_q;
          lo_d = qneg_q ? -quo_q : quo_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush && state_q != StIdle) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      cnt_d   = 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      cnt_q   <= 5'd0;
      opa_q   <= 32'd0;
      opb_q   <= 32'd0;
      sgn_q   <= 1'b0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

`ifdef MDU_DIV0_FLAG_EN
  logic div0_q;

  always_ff @(posedge clk) begin
    if (rst) div0_q <= 1'b0;
    else     div0_q <= (state_q == StFix) && dz_q && !flush;
  end

  assign div0 = div0_q;
`endif

endmodule
